// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with a valid/ready handshake on both sides.
module mdu_seq #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  input  logic [2:0]      opcode,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            zero_flag
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNTW-1:0] LAST_IT  = CNTW'(XLEN - 1);

  state_t            state, state_nx;
  logic [CNTW-1:0]   cnt;
  logic [XLEN-1:0]   res_q;
  logic              zero_q;

  // Datapath state for the operation in flight
  logic [2:0]        op;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  // Request decode
  logic              is_div_in, sgn_a_in, sgn_b_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              accept, last_it;

  // One iteration and final result
  logic [XLEN:0]     shifted, msum;
  logic [XLEN-1:0]   diff, rem_nx;
  logic              ge;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign res       = res_q;
  assign zero_flag = zero_q && out_valid;

  assign accept  = in_valid && in_ready && !kill;
  assign last_it = (cnt == LAST_IT);

  // MULH is signed*signed, MULHSU signed*unsigned; DIV/REM are signed on both sides.
  assign is_div_in = opcode[2];
  assign sgn_a_in  = is_div_in ? !opcode[0] : (opcode == 3'd1 || opcode == 3'd2);
  assign sgn_b_in  = is_div_in ? !opcode[0] : (opcode == 3'd1);
  assign mag_a     = (sgn_a_in && opr_a[XLEN-1]) ? -opr_a : opr_a;
  assign mag_b     = (sgn_b_in && opr_b[XLEN-1]) ? -opr_b : opr_b;

  assign div_zero    = is_div_in && (opr_b == '0);
  assign div_ovf     = is_div_in && !opcode[0] && (opr_a == INT_MIN) && (opr_b == '1);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (opcode[1] ? opr_a : '1)
                                : (opcode[1] ? '0    : opr_a);

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient}
  // for divide; opnd is the multiplicand or the divisor.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_step = acc;
    shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = shifted[XLEN-1:0] - opnd;
    ge       = (shifted >= {1'b0, opnd});
    rem_nx   = ge ? diff : shifted[XLEN-1:0];
    msum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    if (op[2]) acc_step = {rem_nx, acc[XLEN-2:0], ge};
    else       acc_step = {msum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[XLEN-1:0]      : acc_step[XLEN-1:0];
    rem_fix  = neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (op[2])              final_res = op[1] ? rem_fix : quo_fix;
    else if (op[1:0] == '0) final_res = prod_fix[XLEN-1:0];
    else                    final_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = special ? DONE : CALC;
      CALC:    if (kill) state_nx = IDLE;
               else if (last_it) state_nx = DONE;
      DONE:    if (kill || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept && special) begin
            res_q  <= special_res;
            zero_q <= (special_res == '0);
          end
        end
        CALC: begin
          if (kill || last_it) cnt <= '0;
          else                 cnt <= cnt + 1'b1;
          if (!kill && last_it) begin
            res_q  <= final_res;
            zero_q <= (final_res == '0);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; the FSM never consumes them before an
  // accept has loaded them, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      op    <= opcode;
      neg_q <= sgn_a_in ^ sgn_b_in ? (opr_a[XLEN-1] & sgn_a_in) ^ (opr_b[XLEN-1] & sgn_b_in)
                                   : (opr_a[XLEN-1] & sgn_a_in) ^ (opr_b[XLEN-1] & sgn_b_in);
      neg_r <= is_div_in && sgn_a_in && opr_a[XLEN-1];
      opnd  <= is_div_in ? mag_b : mag_a;
      acc   <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: scoreboard of expected results, latency,
// hold, kill and reset checks.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] opr_a = '0;
  logic [31:0] opr_b = '0;
  logic [2:0]  opcode = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        zero_flag;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          stray   = 0;
  bit          out_allowed = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mdu_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opr_a(opr_a), .opr_b(opr_b), .opcode(opcode), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .zero_flag(zero_flag)
  );

  // Any out_valid outside a requested result window is a spurious pulse.
  always @(negedge clk) if (!rst && out_valid && !out_allowed) stray++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    ua  = {32'b0, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input int hold,
                       input string tag);
    int          lat;
    logic [31:0] held, want;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; opcode = op; opr_a = a; opr_b = b;
    @(posedge clk);
    exp_q.push_back(exp);
    out_allowed = 1'b1;
    #1;
    in_valid = 1'b0; opcode = 3'($urandom); opr_a = $urandom; opr_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    held = res;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_res"}, res, held);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    want = exp_q.pop_front();
    check({tag, "_res"}, res, want);
    check({tag, "_zero_flag"}, zero_flag, (want == 0));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_allowed = 1'b0;
    check({tag, "_post_in_ready"}, in_ready, 1);
    check({tag, "_post_valid"}, out_valid, 0);
  endtask

  // Start an op, then abort it with kill or rst while cnt == iter.
  task automatic abort_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int iter, input bit use_rst, input string tag);
    @(negedge clk);
    in_valid = 1'b1; opcode = op; opr_a = a; opr_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (iter) @(posedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else kill = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; kill = 1'b0;
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_valid"}, out_valid, 0);
    if (use_rst) begin
      check({tag, "_res"}, res, 0);
      check({tag, "_zero_flag"}, zero_flag, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          rlat;

    @(posedge clk); #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_valid", out_valid, 0);
    check("reset_res", res, 0);
    check("reset_zero_flag", zero_flag, 0);
    @(negedge clk); rst = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0, "mul_m1");
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0, "mulh_m1");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, "mulhu_m1");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 5, "mulhsu_m1");

    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem_m7_2");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 0, "divu_100_7");
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, 0, "remu_100_7");

    do_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "div_by0");
    do_op(3'd6, 32'd5, 32'd0, 32'd5, 1, 0, "rem_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem_ovf");

    // kill in IDLE blocks acceptance
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; opcode = 3'd0; opr_a = 32'd7; opr_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("kill_idle_in_ready", in_ready, 1);
    check("kill_idle_valid", out_valid, 0);

    abort_op(3'd0, 32'd1234, 32'd5678, 10, 1'b0, "kill_calc");
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 33, 0, "mul_3_4");
    abort_op(3'd5, 32'd1000, 32'd3, 10, 1'b1, "rst_calc");
    do_op(3'd5, 32'd9, 32'd3, 32'd3, 33, 0, "divu_9_3");

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = (i == 3) ? 32'h8000_0000 : $urandom;
      rb  = (i % 4 == 0) ? 32'd0 : (i == 3) ? 32'hFFFF_FFFF : $urandom >> (i % 3 * 12);
      rlat = (rop[2] && (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)))
             ? 1 : 33;
      do_op(rop, ra, rb, model(rop, ra, rb), rlat, 0, $sformatf("rand%0d_op%0d", i, rop));
    end

    repeat (3) @(posedge clk);
    #1;
    check("no_stray_out_valid", stray, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
